fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 19 +
 rtl/if_id_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants: default reset PC, bubble instruction,
// FSM state encoding and a saturating-increment helper for the counters.
package riscv_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats stall beats capture. A bubble loads
// the NOP and clears valid but keeps the last PC pair for debug visibility.
module if_id_reg import riscv_pkg::*; #(
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_bubble,     // redirect or explicit flush
   input  logic        i_stall,      // hold everything
   input  logic        i_wait,       // memory not ready, InstrF invalid
   input  logic        i_active,     // fetch FSM past its boot cycle
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid,
   output logic        o_capture     // a real instruction is loaded this cycle
);

   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [31:0] r_pc_plus4;
   logic        r_valid;

   // Capture qualifies only when nothing with higher priority applies.
   assign o_capture = i_active & ~i_bubble & ~i_stall & ~i_wait;

   // Register update in priority order: bubble, stall, wait-bubble, capture.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instr    <= NOP_INSTR;
         r_pc       <= 32'd0;
         r_pc_plus4 <= 32'd0;
         r_valid    <= 1'b0;
      end else if (i_bubble) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_stall) begin
         r_valid <= r_valid;
      end else if (i_wait) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_active) begin
         r_instr    <= i_instr;
         r_pc       <= i_pc;
         r_pc_plus4 <= i_pc + 32'd4;
         r_valid    <= 1'b1;
      end
   end

   assign o_instr    = r_instr;
   assign o_pc       = r_pc;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, BOOT/RUN/WAIT sequencing around a
// slow instruction memory, sticky misalignment flag and saturating counters.
// The IF/ID register itself lives in if_id_reg.
module fetch_stage import riscv_pkg::*; #(
   parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [31:0] InstrF,
   input  logic        mem_waitrequest,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        misalign_err,
   output logic [31:0] fetch_cnt,
   output logic [31:0] wait_cnt
);

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_wait_cnt;
   logic        r_misalign;
   logic        w_active;
   logic        w_redirect;
   logic        w_capture;

   // The boot cycle ignores every request; afterwards a redirect always wins.
   assign w_active   = (r_state != ST_BOOT);
   assign w_redirect = w_active & PCSrcE;

   // Next state: a redirect lands in RUN even if memory is still busy.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_BOOT:          w_state_next = ST_RUN;
         ST_RUN, ST_WAIT:  w_state_next = (!PCSrcE && mem_waitrequest) ? ST_WAIT : ST_RUN;
         default:          w_state_next = ST_BOOT;
      endcase
   end

   // Next PC: redirect (word-aligned), else advance when the fetch completed.
   always_comb begin
      w_pc_next = r_pc;
      if (w_redirect)
         w_pc_next = {PCTargetE[31:2], 2'b00};
      else if (w_active && !StallF && !mem_waitrequest)
         w_pc_next = r_pc + 32'd4;
   end

   // State, PC, sticky error flag and the two saturating counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_BOOT;
         r_pc        <= RESET_PC;
         r_misalign  <= 1'b0;
         r_fetch_cnt <= 32'd0;
         r_wait_cnt  <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (w_redirect && (PCTargetE[1:0] != 2'b00))
            r_misalign <= 1'b1;
         if (w_capture)
            r_fetch_cnt <= sat_inc(r_fetch_cnt);
         if (w_active && mem_waitrequest)
            r_wait_cnt <= sat_inc(r_wait_cnt);
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .i_rst_n    (rst),
      .i_bubble   (PCSrcE | FlushD),
      .i_stall    (StallD),
      .i_wait     (mem_waitrequest),
      .i_active   (w_active),
      .i_instr    (InstrF),
      .i_pc       (r_pc),
      .o_instr    (InstrD),
      .o_pc       (PCD),
      .o_pc_plus4 (PCPlus4D),
      .o_valid    (ValidD),
      .o_capture  (w_capture)
   );

   assign PCF          = r_pc;
   assign misalign_err = r_misalign;
   assign fetch_cnt    = r_fetch_cnt;
   assign wait_cnt     = r_wait_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A cycle-level model of the fetch contract
// (what gets delivered, what the PC does, what gets counted) is checked
// against the DUT after every clock; literal checks pin key scenarios.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = 32'd0;
   logic        StallF = 1'b0;
   logic        StallD = 1'b0;
   logic        FlushD = 1'b0;
   logic [31:0] InstrF;
   logic        mem_waitrequest = 1'b0;
   logic [31:0] PCF, InstrD, PCD, PCPlus4D, fetch_cnt, wait_cnt;
   logic        ValidD, misalign_err;

   logic [31:0] mem [0:63];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        sat_req = 1'b0;

   // Model state
   logic        m_booted = 1'b0;
   logic [31:0] m_pc = 32'd0, m_instr = NOP, m_pcd = 32'd0, m_pcp4 = 32'd0;
   logic        m_valid = 1'b0, m_mis = 1'b0;
   logic [31:0] m_fcnt = 32'd0, m_wcnt = 32'd0;

   always #5 clk = ~clk;

   assign InstrF = mem[PCF[7:2]];

   fetch_stage dut (
      .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .InstrF(InstrF),
      .mem_waitrequest(mem_waitrequest), .PCF(PCF), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
      .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .wait_cnt(wait_cnt)
   );

   function automatic logic [31:0] bump(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Reference behaviour: first edge after reset only boots; afterwards an
   // instruction is delivered when nothing blocks it, the PC follows
   // redirect > advance-on-completed-fetch > hold.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_booted <= 1'b0; m_pc <= 32'd0; m_instr <= NOP; m_pcd <= 32'd0;
         m_pcp4 <= 32'd0; m_valid <= 1'b0; m_mis <= 1'b0;
         m_fcnt <= 32'd0; m_wcnt <= 32'd0;
      end else if (!m_booted) begin
         m_booted <= 1'b1;
      end else begin
         if (PCSrcE && PCTargetE[1:0] != 2'b00) m_mis <= 1'b1;
         if (mem_waitrequest) m_wcnt <= bump(m_wcnt);
         if (PCSrcE || FlushD || (!StallD && mem_waitrequest)) begin
            m_instr <= NOP; m_valid <= 1'b0;
            if (sat_req) m_fcnt <= 32'hFFFF_FFFE;
         end else if (!StallD) begin
            m_instr <= mem[m_pc[7:2]]; m_pcd <= m_pc; m_pcp4 <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_fcnt  <= bump(sat_req ? 32'hFFFF_FFFE : m_fcnt);
         end else if (sat_req) begin
            m_fcnt <= 32'hFFFF_FFFE;
         end
         if (PCSrcE) m_pc <= {PCTargetE[31:2], 2'b00};
         else if (!StallF && !mem_waitrequest) m_pc <= m_pc + 32'd4;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%08h required=%08h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("model.PCF", PCF, m_pc);
      chk("model.InstrD", InstrD, m_instr);
      chk("model.PCD", PCD, m_pcd);
      chk("model.PCPlus4D", PCPlus4D, m_pcp4);
      chk("model.ValidD", {31'd0, ValidD}, {31'd0, m_valid});
      chk("model.misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("model.fetch_cnt", fetch_cnt, m_fcnt);
      chk("model.wait_cnt", wait_cnt, m_wcnt);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      @(negedge clk);
      compare_model();
      $display("[TB] cycle %-10s PCF=%08h InstrD=%08h PCD=%08h V=%0d fcnt=%0d wcnt=%0d",
               tag, PCF, InstrD, PCD, ValidD, fetch_cnt, wait_cnt);
   endtask

   task automatic idle_inputs();
      PCSrcE = 1'b0; PCTargetE = 32'd0; StallF = 1'b0; StallD = 1'b0;
      FlushD = 1'b0; mem_waitrequest = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0033 | (i << 8);

      #1 rst = 1'b0;
      step("reset"); step("reset");
      chk("rst.PCF", PCF, 32'h0);
      chk("rst.InstrD", InstrD, NOP);
      chk("rst.ValidD", {31'd0, ValidD}, 32'd0);
      chk("rst.fetch_cnt", fetch_cnt, 32'd0);
      rst = 1'b1;

      // Boot then stream: PCF 0,0,4,8
      step("boot");
      chk("boot.PCF", PCF, 32'h0);
      chk("boot.ValidD", {31'd0, ValidD}, 32'd0);
      step("run");
      chk("first.PCF", PCF, 32'h4);
      chk("first.InstrD", InstrD, 32'hA000_0033);
      chk("first.ValidD", {31'd0, ValidD}, 32'd1);
      chk("first.fetch_cnt", fetch_cnt, 32'd1);
      chk("first.PCPlus4D", PCPlus4D, 32'h4);
      step("run");
      chk("second.PCF", PCF, 32'h8);

      // Three wait cycles at PCF=8
      mem_waitrequest = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step("wait");
         chk("wait.PCF", PCF, 32'h8);
         chk("wait.InstrD", InstrD, NOP);
         chk("wait.ValidD", {31'd0, ValidD}, 32'd0);
      end
      chk("wait.wait_cnt", wait_cnt, 32'd3);
      mem_waitrequest = 1'b0;
      step("resume");
      chk("resume.InstrD", InstrD, 32'hA000_0233);
      chk("resume.PCD", PCD, 32'h8);
      step("run");
      chk("pre_stall.PCF", PCF, 32'h10);

      // Full stall at PCF=0x10
      StallF = 1'b1; StallD = 1'b1;
      step("stall"); step("stall");
      chk("stall.PCF", PCF, 32'h10);
      chk("stall.InstrD", InstrD, 32'hA000_0333);
      chk("stall.PCD", PCD, 32'hC);
      chk("stall.fetch_cnt", fetch_cnt, 32'd4);

      // Redirect beats wait and StallD
      PCSrcE = 1'b1; PCTargetE = 32'h40; mem_waitrequest = 1'b1;
      step("redirect");
      chk("redir.PCF", PCF, 32'h40);
      chk("redir.ValidD", {31'd0, ValidD}, 32'd0);
      idle_inputs();
      step("run");
      chk("redir.InstrD", InstrD, 32'hA000_1033);
      chk("redir.PCF_next", PCF, 32'h44);

      // Misaligned redirect, sticky flag
      chk("mis.before", {31'd0, misalign_err}, 32'd0);
      PCSrcE = 1'b1; PCTargetE = 32'h22;
      step("misalign");
      chk("mis.PCF", PCF, 32'h20);
      chk("mis.flag", {31'd0, misalign_err}, 32'd1);
      idle_inputs();
      for (int k = 0; k < 10; k++) step("run");
      chk("mis.sticky", {31'd0, misalign_err}, 32'd1);

      // Flush, then illegal StallF=0/StallD=1
      FlushD = 1'b1;
      step("flush");
      chk("flush.ValidD", {31'd0, ValidD}, 32'd0);
      chk("flush.InstrD", InstrD, NOP);
      FlushD = 1'b0; StallD = 1'b1;
      step("stallD"); step("stallD");
      StallD = 1'b0;
      step("run");

      // Saturation of fetch_cnt
      sat_req = 1'b1;
      #1 force dut.r_fetch_cnt = 32'hFFFF_FFFE;
      #1 release dut.r_fetch_cnt;
      step("sat");
      sat_req = 1'b0;
      step("sat"); step("sat");
      chk("sat.fetch_cnt", fetch_cnt, 32'hFFFF_FFFF);

      // Reset in the middle of a wait
      mem_waitrequest = 1'b1;
      step("wait");
      #2 rst = 1'b0;
      #1;
      chk("midrst.PCF", PCF, 32'h0);
      chk("midrst.wait_cnt", wait_cnt, 32'd0);
      mem_waitrequest = 1'b0;
      step("reset");
      rst = 1'b1;
      step("boot");
      chk("reboot.PCF", PCF, 32'h0);
      step("run");
      chk("reboot.InstrD", InstrD, 32'hA000_0033);
      chk("reboot.PCF_next", PCF, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
